// File: rtl/inst_sram_resp.sv
// Instruction-side SRAM responder: a 64-bit word array answering 32-bit fetches
// through a LATENCY-deep response pipeline that freezes while the pipeline is held.
module inst_sram_resp #(
    parameter int          DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 1,
    parameter int          STALL_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               isram_e,
    input  logic [63:0]        isram_addr,
    input  logic               ld_e,
    input  logic [63:0]        ld_addr,
    input  logic [63:0]        ld_data,
    output logic               inst_valid,
    output logic [63:0]        inst_addr,
    output logic [31:0]        inst,
    output logic               inst_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Only stall bits 0, 1 and 3 freeze the fetch path.
    localparam logic [STALL_W-1:0] STALL_USED = STALL_W'(11);

    logic [63:0] mem_q [DEPTH];

    logic        stgValid_q [LATENCY];
    logic [63:0] stgAddr_q  [LATENCY];
    logic [31:0] stgData_q  [LATENCY];
    logic        stgErr_q   [LATENCY];

    logic        hold;
    logic        accept;
    logic [63:0] fetchOff;
    logic [60:0] fetchIdx;
    logic        fetchInRange;
    logic        fetchErr;
    logic [63:0] rdWord;
    logic [63:0] ldOff;
    logic [60:0] ldIdx;
    logic        ldInRange;

    logic        stg0Valid_d;
    logic [63:0] stg0Addr_d;
    logic [31:0] stg0Data_d;
    logic        stg0Err_d;

    logic        unusedBits;

    always_comb begin
        hold         = stall[3] | stall[1] | stall[0];
        accept       = isram_e & ~hold;

        fetchOff     = isram_addr - BASE;
        fetchIdx     = fetchOff[63:3];
        fetchInRange = (isram_addr >= BASE) && (fetchIdx < 61'(DEPTH));
        fetchErr     = !fetchInRange || (isram_addr[1:0] != 2'b00);
        rdWord       = fetchInRange ? mem_q[fetchIdx[AW-1:0]] : 64'h0;

        ldOff        = ld_addr - BASE;
        ldIdx        = ldOff[63:3];
        ldInRange    = (ld_addr >= BASE) && (ldIdx < 61'(DEPTH));
    end

    // Bubbles and faults carry zero data so nothing stale ever reaches inst.
    always_comb begin
        stg0Valid_d = accept;
        stg0Addr_d  = accept ? isram_addr : 64'h0;
        stg0Err_d   = accept & fetchErr;
        stg0Data_d  = 32'h0;
        if (accept && !fetchErr) begin
            stg0Data_d = isram_addr[2] ? rdWord[63:32] : rdWord[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stgValid_q[i] <= 1'b0;
                stgAddr_q[i]  <= 64'h0;
                stgData_q[i]  <= 32'h0;
                stgErr_q[i]   <= 1'b0;
            end
        end else if (!hold) begin
            stgValid_q[0] <= stg0Valid_d;
            stgAddr_q[0]  <= stg0Addr_d;
            stgData_q[0]  <= stg0Data_d;
            stgErr_q[0]   <= stg0Err_d;
            for (int i = 1; i < LATENCY; i++) begin
                stgValid_q[i] <= stgValid_q[i-1];
                stgAddr_q[i]  <= stgAddr_q[i-1];
                stgData_q[i]  <= stgData_q[i-1];
                stgErr_q[i]   <= stgErr_q[i-1];
            end
        end
    end

    // Backdoor writes ignore hold; the fetch above has already read the old word this edge.
    always_ff @(posedge clk) begin
        if (!rst && ld_e && ldInRange) begin
            mem_q[ldIdx[AW-1:0]] <= ld_data;
        end
    end

    assign inst_valid = stgValid_q[LATENCY-1];
    assign inst_addr  = stgAddr_q[LATENCY-1];
    assign inst       = stgData_q[LATENCY-1];
    assign inst_err   = stgErr_q[LATENCY-1];

    assign unusedBits = ^{stall & ~STALL_USED, fetchOff[2:0], ldOff[2:0]};

endmodule

// File: tb/tb_inst_sram_resp.sv
// Scoreboard bench for inst_sram_resp: LATENCY=1 and LATENCY=3 instances share one
// directed stimulus stream; expected responses are queued per instance and checked by a monitor.
module tb_inst_sram_resp;
    typedef struct {
        int          side;
        int          due;
        logic [63:0] addr;
        logic [31:0] inst;
        logic        err;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  stall;
    logic        isram_e;
    logic [63:0] isram_addr;
    logic        ld_e;
    logic [63:0] ld_addr;
    logic [63:0] ld_data;

    logic        v1, v3, e1, e3;
    logic [63:0] a1, a3;
    logic [31:0] d1, d3;

    int          testCount = 0;
    int          failCount = 0;
    int          advCount  = 0;
    bit          started   = 0;
    bit          lastRst   = 0;
    bit          lastAdv   = 0;
    int          LAT [2]   = '{1, 3};
    expEntry_t   sb [$];
    logic [128:0] prevOut [2];

    inst_sram_resp #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .isram_e(isram_e), .isram_addr(isram_addr),
        .ld_e(ld_e), .ld_addr(ld_addr), .ld_data(ld_data),
        .inst_valid(v1), .inst_addr(a1), .inst(d1), .inst_err(e1)
    );

    inst_sram_resp #(.LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .stall(stall), .isram_e(isram_e), .isram_addr(isram_addr),
        .ld_e(ld_e), .ld_addr(ld_addr), .ld_data(ld_data),
        .inst_valid(v3), .inst_addr(a3), .inst(d3), .inst_err(e3)
    );

    always #5 clk = ~clk;

    // advCount counts edges that move the pipeline; a response is due LATENCY moves after issue.
    always @(posedge clk) begin
        started <= 1'b1;
        lastRst <= rst;
        lastAdv <= !rst && !(stall[3] | stall[1] | stall[0]);
        if (!rst && !(stall[3] | stall[1] | stall[0])) advCount <= advCount + 1;
    end

    task automatic check(input string name, input int side, input logic [128:0] act, input logic [128:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s (LATENCY=%0d): got %0h, expected %0h", name, LAT[side], act, exp);
        end
    endtask

    task automatic checkOutput(input int side, input logic v, input logic [63:0] a,
                               input logic [31:0] d, input logic e);
        int  idx;
        bit  dueNow;
        logic [128:0] cur;
        cur = {v, e, a, d, 31'h0};
        if (!started) return;
        if (lastRst) begin
            check("reset_clear", side, cur, 129'h0);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].side == side) sb.delete(i);
            end
        end else if (!lastAdv) begin
            check("hold_stable", side, cur, prevOut[side]);
        end else begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (idx < 0 && sb[i].side == side) idx = i;
            end
            dueNow = (idx >= 0) && (sb[idx].due == advCount);
            check("inst_valid", side, 129'(v), 129'(dueNow));
            if (dueNow) begin
                check("inst_addr", side, 129'(a), 129'(sb[idx].addr));
                check("inst", side, 129'(d), 129'(sb[idx].inst));
                check("inst_err", side, 129'(e), 129'(sb[idx].err));
                sb.delete(idx);
            end
        end
        prevOut[side] = cur;
    endtask

    always @(negedge clk) begin
        checkOutput(0, v1, a1, d1, e1);
        checkOutput(1, v3, a3, d3, e3);
    end

    task automatic applyStimulus(input logic rstV, input logic [4:0] stallV, input logic e,
                                 input logic [63:0] addr, input logic [31:0] expInst, input logic expErr,
                                 input logic ldE, input logic [63:0] ldA, input logic [63:0] ldD);
        @(negedge clk);
        rst        = rstV;
        stall      = stallV;
        isram_e    = e;
        isram_addr = addr;
        ld_e       = ldE;
        ld_addr    = ldA;
        ld_data    = ldD;
        if (e && !rstV && !(stallV[3] | stallV[1] | stallV[0])) begin
            for (int s = 0; s < 2; s++) begin
                sb.push_back('{side: s, due: advCount + LAT[s], addr: addr, inst: expInst, err: expErr});
            end
        end
    endtask

    task automatic fetch(input logic [63:0] addr, input logic [31:0] expInst, input logic expErr);
        applyStimulus(1'b0, 5'b0, 1'b1, addr, expInst, expErr, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic load(input logic [63:0] addr, input logic [63:0] data);
        applyStimulus(1'b0, 5'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b1, addr, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic stalled(input logic [4:0] stallV, input logic [63:0] addr);
        applyStimulus(1'b0, stallV, 1'b1, addr, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    initial begin
        int pending;
        rst = 1'b1; stall = 5'b0; isram_e = 1'b0; isram_addr = 64'h0;
        ld_e = 1'b0; ld_addr = 64'h0; ld_data = 64'h0;
        for (int i = 0; i < 2; i++) prevOut[i] = 129'h0;
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 5'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);

        // Preload; the last two writes are out of range and must not alias onto words 0 or 4095.
        load(64'h8000_0000, 64'h0010_0093_0000_0013);
        load(64'h8000_0008, 64'h1111_2222_3333_4444);
        load(64'h8000_0013, 64'h5555_6666_7777_8888);
        load(64'h8000_7FF8, 64'hDEAD_BEEF_CAFE_F00D);
        load(64'h8000_8000, 64'h0BAD_0BAD_0BAD_0BAD);
        load(64'h7FFF_FFF8, 64'h0BAD_0BAD_0BAD_0BAD);
        idle(1);

        fetch(64'h8000_0000, 32'h0000_0013, 1'b0);
        fetch(64'h8000_0004, 32'h0010_0093, 1'b0);
        fetch(64'h8000_0010, 32'h7777_8888, 1'b0);
        fetch(64'h8000_0014, 32'h5555_6666, 1'b0);
        fetch(64'h8000_7FF8, 32'hCAFE_F00D, 1'b0);
        fetch(64'h8000_7FFC, 32'hDEAD_BEEF, 1'b0);
        idle(4);

        fetch(64'h8000_0008, 32'h3333_4444, 1'b0);
        stalled(5'b01000, 64'h8000_000C);
        stalled(5'b01000, 64'h8000_000C);
        fetch(64'h8000_000C, 32'h1111_2222, 1'b0);
        stalled(5'b00010, 64'h8000_0000);
        stalled(5'b00001, 64'h8000_0000);
        applyStimulus(1'b0, 5'b00100, 1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 64'h0, 64'h0);
        applyStimulus(1'b0, 5'b10000, 1'b1, 64'h8000_0004, 32'h0010_0093, 1'b0, 1'b0, 64'h0, 64'h0);
        idle(4);

        fetch(64'h7FFF_FFFC, 32'h0, 1'b1);
        fetch(64'h8000_8000, 32'h0, 1'b1);
        fetch(64'h8000_0002, 32'h0, 1'b1);
        fetch(64'h8000_0001, 32'h0, 1'b1);
        fetch(64'hFFFF_FFFF_FFFF_FFF0, 32'h0, 1'b1);
        idle(4);

        applyStimulus(1'b0, 5'b0, 1'b1, 64'h8000_0008, 32'h3333_4444, 1'b0,
                      1'b1, 64'h8000_0008, 64'hAAAA_BBBB_CCCC_DDDD);
        fetch(64'h8000_0008, 32'hCCCC_DDDD, 1'b0);
        fetch(64'h8000_000C, 32'hAAAA_BBBB, 1'b0);
        idle(4);

        // Reset with requests in flight, also holding stall and a load that must be suppressed.
        fetch(64'h8000_0000, 32'h0000_0013, 1'b0);
        fetch(64'h8000_0004, 32'h0010_0093, 1'b0);
        applyStimulus(1'b1, 5'b01000, 1'b1, 64'h8000_0000, 32'h0, 1'b0,
                      1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(4);
        fetch(64'h8000_0000, 32'h0000_0013, 1'b0);
        fetch(64'h8000_7FFC, 32'hDEAD_BEEF, 1'b0);
        idle(6);

        for (int s = 0; s < 2; s++) begin
            pending = 0;
            foreach (sb[i]) if (sb[i].side == s) pending++;
            check("drained", s, 129'(pending), 129'h0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
